lz4_word_fetch: RTL and testbench

//  Upstream feeder of the LZ4 96-bit byte shifter. On start, reads ceil(len/4) 32-bit words of a source block

---
 rtl/lz4_word_fetch_if.sv | 29 ++
 rtl/lz4_word_fetch.sv | 149 ++++++++++++++
 tb/tb_lz4_word_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lz4_word_fetch_if.sv
// Bus bundle between the LZ4 word fetcher, its source RAM and the byte shifter.
// The fetcher sits on the slave side; the environment (controller, RAM, shifter) drives the master side.
interface lz4_word_fetch_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [LEN_W-1:0]  src_len;
    logic              busy;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [31:0]       ram_rd_data;
    logic              in_req;
    logic [31:0]       out_data;
    logic              data_valid;
    logic              load_done;
    logic [2:0]        tail_bytes;

    modport slave (
        input  start, src_addr, src_len, ram_rd_data, in_req,
        output busy, ram_rd_en, ram_rd_addr, out_data, data_valid, load_done, tail_bytes
    );

    modport master (
        output start, src_addr, src_len, ram_rd_data, in_req,
        input  busy, ram_rd_en, ram_rd_addr, out_data, data_valid, load_done, tail_bytes
    );
endinterface

// File: rtl/lz4_word_fetch.sv
// LZ4 word fetcher: reads ceil(len/4) words of a source block from a synchronous-read RAM,
// buffers them in a 2-entry prefetch FIFO and hands one word per load request to the byte shifter.
// Bytes past the end of the block are zeroed in the final word.
module lz4_word_fetch #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input logic              clk,
    input logic              rstN,
    lz4_word_fetch_if.slave  bus
);
    localparam int CW = LEN_W - 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state;
    logic              busy_q;
    logic              load_done_q;
    logic [2:0]        tail_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_last_q;       // the read currently strobed is the final word
    logic [CW-1:0]     issue_left_q;    // reads still to issue after the current one
    logic [CW-1:0]     deliver_left_q;  // words still to hand to the shifter
    logic              ret_valid_q;     // RAM data on ram_rd_data belongs to this block
    logic              ret_last_q;      // ... and it is the final word
    logic [1:0]        fifo_count_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [31:0]       fifo_mem [2];

    logic          push;
    logic          pop;
    logic [1:0]    count_next;
    logic          issue_ok;
    logic [CW-1:0] words;
    logic [31:0]   masked;

    // Block size in words and FIFO bookkeeping for this cycle.
    always_comb begin
        // NOTE: every signal gets a default at the top of a combinational block so no path can infer a latch.
        words      = CW'(bus.src_len[LEN_W-1:2]) + CW'(|bus.src_len[1:0]);
        push       = ret_valid_q;
        pop        = bus.in_req && (fifo_count_q != 2'd0) && busy_q;
        count_next = fifo_count_q + {1'b0, push} - {1'b0, pop};
        // A new read is allowed only if the FIFO can still absorb it even if the shifter stops
        // requesting: words buffered after this edge plus the read already on its way must be < 2.
        issue_ok   = (count_next == 2'd0) || ((count_next == 2'd1) && !rd_en_q);
    end

    // Zero the bytes beyond the block end in the final word as it returns from the RAM.
    always_comb begin
        masked = bus.ram_rd_data;
        if (ret_last_q) begin
            unique case (tail_q)
                3'd1:    masked[23:0] = '0;
                3'd2:    masked[15:0] = '0;
                3'd3:    masked[7:0]  = '0;
                default: ;
            endcase
        end
    end

    // Block sequencer: accept, read issue, delivery accounting and completion flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
            tail_q         <= 3'd4;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            rd_last_q      <= 1'b0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            ret_valid_q    <= 1'b0;
            ret_last_q     <= 1'b0;
            fifo_count_q   <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            ret_valid_q  <= rd_en_q;
            ret_last_q   <= rd_en_q && rd_last_q;
            fifo_count_q <= count_next;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;

            unique case (state)
                IDLE, DONE: begin
                    rd_en_q <= 1'b0;
                    if (bus.start) begin
                        rd_addr_q <= bus.src_addr;
                        tail_q    <= (bus.src_len[1:0] == 2'b00) ? 3'd4 : {1'b0, bus.src_len[1:0]};
                        if (words == '0) begin
                            state       <= DONE;
                            busy_q      <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            busy_q         <= 1'b1;
                            load_done_q    <= 1'b0;
                            rd_en_q        <= 1'b1;
                            rd_last_q      <= (words == CW'(1));
                            issue_left_q   <= words - CW'(1);
                            deliver_left_q <= words;
                            state          <= (words == CW'(1)) ? DRAIN : FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue_ok) begin
                        rd_en_q      <= 1'b1;
                        rd_addr_q    <= rd_addr_q + ADDR_W'(1);
                        issue_left_q <= issue_left_q - CW'(1);
                        rd_last_q    <= (issue_left_q == CW'(1));
                        if (issue_left_q == CW'(1)) state <= DRAIN;
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                end
                DRAIN: rd_en_q <= 1'b0;
                default: state <= IDLE;
            endcase

            if (pop) begin
                deliver_left_q <= deliver_left_q - CW'(1);
                if (deliver_left_q == CW'(1)) begin
                    state       <= DONE;
                    busy_q      <= 1'b0;
                    load_done_q <= 1'b1;
                end
            end
        end
    end

    // Prefetch FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; fifo_count_q alone decides which entries are meaningful.
        if (push) fifo_mem[wr_ptr_q] <= masked;
    end

    assign bus.busy        = busy_q;
    assign bus.load_done   = load_done_q;
    assign bus.tail_bytes  = tail_q;
    assign bus.ram_rd_en   = rd_en_q;
    assign bus.ram_rd_addr = rd_addr_q;
    assign bus.data_valid  = pop;
    assign bus.out_data    = fifo_mem[rd_ptr_q];
endmodule

// File: tb/tb_lz4_word_fetch.sv
// Self-checking bench for lz4_word_fetch: a reference model turns each accepted block into the
// expected RAM address sequence and the expected word stream; monitors compare as the DUT produces them.
module tb_lz4_word_fetch;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    lz4_word_fetch_if #(.ADDR_W(10), .LEN_W(16)) bus ();

    lz4_word_fetch #(.ADDR_W(10), .LEN_W(16)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    logic [31:0] ram [1024];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_cnt, dv_cnt, issued, delivered;
    int dv_cyc[$];
    logic [31:0] exp_q[$];
    logic [9:0]  addr_q[$];
    logic [31:0] last_dv_data;
    logic [2:0]  exp_tail;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM; returns noise when not read so stale returns are noticed.
    always @(posedge clk) bus.ram_rd_data <= bus.ram_rd_en ? ram[bus.ram_rd_addr] : $urandom;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one block becomes a list of word addresses and expected words.
    task automatic push_block(input logic [9:0] addr, input int len);
        int n, tail, sh;
        logic [9:0] a;
        logic [31:0] w;
        n    = (len + 3) / 4;
        tail = (len % 4 == 0) ? 4 : len % 4;
        exp_tail = 3'(tail);
        for (int i = 0; i < n; i++) begin
            a = 10'((int'(addr) + i) % 1024);
            addr_q.push_back(a);
            w = ram[a];
            if (i == n - 1) begin
                sh = 8 * (4 - tail);
                w = (w >> sh) << sh;
            end
            exp_q.push_back(w);
        end
    endtask

    // Monitor: checks every read strobe and every delivered word against the model queues.
    always @(negedge clk) begin
        if (rstN) begin
            if (bus.ram_rd_en) begin
                rd_cnt++;
                issued++;
                check("read_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) check("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(addr_q.pop_front()));
                check("occupancy_le_2", 32'((issued - delivered) <= 2), 32'd1);
            end
            if (bus.data_valid) begin
                check("dv_needs_in_req", 32'(bus.in_req), 32'd1);
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
                last_dv_data = bus.out_data;
                delivered++;
                dv_cnt++;
                dv_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic req_of(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k / 3) % 2) == 0;
            default: return $urandom_range(0, 99) < 65;
        endcase
    endfunction

    // Issue one block and wait (bounded) for load_done; called right after a posedge.
    task automatic run_block(input logic [9:0] addr, input int len, input int mode, input bit ghost,
                             output int t0, output int done_cyc, output logic ld_first);
        push_block(addr, len);
        rd_cnt = 0;
        dv_cnt = 0;
        dv_cyc.delete();
        ld_first = 1'bx;
        bus.src_addr = addr;
        bus.src_len  = 16'(len);
        bus.start    = 1'b1;
        bus.in_req   = req_of(mode, 0);
        t0 = cyc;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.src_addr = 10'($urandom);
        bus.src_len  = 16'($urandom);
        bus.in_req   = req_of(mode, 1);
        done_cyc = -1;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            if (k == 1) ld_first = bus.load_done;
            if (bus.load_done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            bus.in_req = req_of(mode, k + 1);
            if (ghost) begin
                bus.start    = (k == 2);
                bus.src_addr = 10'($urandom);
                bus.src_len  = 16'($urandom_range(1, 64));
            end
        end
        check("done_within_budget", 32'(done_cyc >= 0), 32'd1);
        check("words_left_over", 32'(exp_q.size()), 32'd0);
        check("reads_left_over", 32'(addr_q.size()), 32'd0);
        check("tail_bytes", 32'(bus.tail_bytes), 32'(exp_tail));
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ram_rd_en"}, 32'(bus.ram_rd_en), 32'd0);
        check({tag, "_ram_rd_addr"}, 32'(bus.ram_rd_addr), 32'd0);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
        check({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
        check({tag, "_tail_bytes"}, 32'(bus.tail_bytes), 32'd4);
    endtask

    initial begin
        int t0, done_cyc, wait_cnt;
        logic ld_first;
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        ram[10'h010] = 32'h11223344;
        ram[10'h011] = 32'h55667788;
        rstN = 1'b0;
        bus.start = 1'b0;
        bus.src_addr = '0;
        bus.src_len = '0;
        bus.in_req = 1'b0;
        issued = 0;
        delivered = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rstN = 1'b1;
        @(posedge clk); #1;

        // 1: two full words, back-to-back delivery timing
        bus.in_req = 1'b1;
        run_block(10'h010, 8, 0, 1'b0, t0, done_cyc, ld_first);
        check("t1_reads", 32'(rd_cnt), 32'd2);
        check("t1_words", 32'(dv_cnt), 32'd2);
        if (dv_cyc.size() == 2) begin
            check("t1_first_dv_cycle", 32'(dv_cyc[0] - t0), 32'd3);
            check("t1_second_dv_cycle", 32'(dv_cyc[1] - t0), 32'd4);
        end
        check("t1_load_done_cycle", 32'(done_cyc - t0), 32'd5);

        // 2: partial final word
        ram[10'h011] = 32'hAABBCCDD;
        run_block(10'h010, 6, 0, 1'b0, t0, done_cyc, ld_first);
        check("t2_last_word", last_dv_data, 32'hAABB0000);
        check("t2_tail", 32'(bus.tail_bytes), 32'd2);

        // 3: stalling shifter
        run_block(10'($urandom), 32, 1, 1'b0, t0, done_cyc, ld_first);
        check("t3_words", 32'(dv_cnt), 32'd8);

        // 4: empty block, then a one-word block clears load_done
        run_block(10'($urandom), 0, 0, 1'b0, t0, done_cyc, ld_first);
        check("t4_done_cycle", 32'(done_cyc - t0), 32'd1);
        check("t4_reads", 32'(rd_cnt), 32'd0);
        check("t4_words", 32'(dv_cnt), 32'd0);
        run_block(10'($urandom), 4, 0, 1'b0, t0, done_cyc, ld_first);
        check("t4_load_done_dropped", 32'(ld_first), 32'd0);

        // 5: address wrap, start pulsed while busy must be ignored
        run_block(10'h3FF, 12, 0, 1'b1, t0, done_cyc, ld_first);
        check("t5_reads", 32'(rd_cnt), 32'd3);

        // 6: asynchronous reset in the middle of a five-word block
        push_block(10'($urandom), 20);
        dv_cnt = 0;
        bus.in_req = 1'b1;
        bus.src_addr = addr_q[0];
        bus.src_len = 16'd20;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_cnt = 0;
        while (dv_cnt < 2 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("t6_two_words_seen", 32'(dv_cnt), 32'd2);
        #2 rstN = 1'b0;
        #1;
        check_reset_values("t6_mid_reset");
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        delivered = 0;
        @(posedge clk); @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        run_block(10'($urandom), 13, 0, 1'b0, t0, done_cyc, ld_first);
        check("t6_words_after_reset", 32'(dv_cnt), 32'd4);

        // Random blocks with a randomly stalling shifter
        for (int b = 0; b < 25; b++) begin
            run_block(10'($urandom), $urandom_range(0, 40), 2, 1'b0, t0, done_cyc, ld_first);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
